mult_err_accum: RTL and testbench

MULT_ERR_ACCUM -- requirements
Module: mult_err_accum

---
 rtl/mult_err_accum.sv | 191 +++++++++++++++++++
 tb/tb_mult_err_accum.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_err_accum.sv
// mult_err_accum: measures the error of an 8x8 approximate multiplier.
// Over a run of 2^N_LOG2 accepted samples it accumulates |a*b - r_apx|,
// counts the samples with a nonzero error and tracks the largest error.
// Optional feature macro: MULT_ERR_MAX_EN enables max_err tracking; without
// it max_err is tied to zero.
//
// Handshake: a sample on a/b/r_apx is consumed on every rising edge where
// in_valid and in_ready are both 1; in_ready is high only in RUN and never
// depends on in_valid. Holding in_valid low inserts a bubble that changes
// nothing.
//
// Pipeline: stage 1 registers the operands on acceptance, stage 2 registers
// the absolute error, and the accumulators fold it in on the following edge.
// DRAIN is held until that final accumulation has landed, so done rises three
// edges after the last acceptance with the results already stable.
module mult_err_accum #(
   parameter int N_LOG2 = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [7:0]          a,
   input  logic [7:0]          b,
   input  logic [15:0]         r_apx,
   output logic                busy,
   output logic                done,
   output logic [15+N_LOG2:0]  sum_abs_err,
   output logic [N_LOG2:0]     err_cnt,
   output logic [15:0]         max_err,
   output logic [1:0]          state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [N_LOG2:0] LAST_CNT = {1'b1, {N_LOG2{1'b0}}};

   state_t              state_q, state_d;
   logic [N_LOG2:0]     cnt_q, cnt_d;
   logic [1:0]          drain_q, drain_d;
   logic                done_q, done_d;

   logic                s1_vld_q;
   logic [7:0]          a_q, b_q;
   logic [15:0]         r_q;
   logic                s2_vld_q;
   logic [15:0]         diff_q;

   logic [15+N_LOG2:0]  sum_q;
   logic [N_LOG2:0]     err_cnt_q;

   logic                accept;
   logic                clear;
   logic [15:0]         prod;
   logic [15:0]         diff;

   assign accept = in_valid && (state_q == ST_RUN);
   assign clear  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   // Control state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         drain_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: start only honoured in IDLE/DONE, sample counting in RUN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drain_d = drain_q;
      done_d  = done_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               done_d  = 1'b0;
            end
         end
         ST_RUN: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT - 1'b1) begin
                  state_d = ST_DRAIN;
                  drain_d = '0;
               end
            end
         end
         ST_DRAIN: begin
            drain_d = drain_q + 1'b1;
            if (drain_q == 2'd2) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Stage 1: capture the operands of an accepted sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         r_q      <= '0;
      end else begin
         s1_vld_q <= accept;
         if (accept) begin
            a_q <= a;
            b_q <= b;
            r_q <= r_apx;
         end
      end
   end

   // Exact product and absolute error of the stage-1 sample.
   always_comb begin
      prod = {8'h00, a_q} * {8'h00, b_q};
      diff = (prod >= r_q) ? (prod - r_q) : (r_q - prod);
   end

   // Stage 2: register the absolute error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_vld_q <= 1'b0;
         diff_q   <= '0;
      end else begin
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            diff_q <= diff;
         end
      end
   end

   // Accumulators: cleared by an honoured start, updated by retiring samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q     <= '0;
         err_cnt_q <= '0;
      end else if (clear) begin
         sum_q     <= '0;
         err_cnt_q <= '0;
      end else if (s2_vld_q) begin
         sum_q     <= sum_q + {{N_LOG2{1'b0}}, diff_q};
         err_cnt_q <= err_cnt_q + {{N_LOG2{1'b0}}, (diff_q != 16'h0000)};
      end
   end

`ifdef MULT_ERR_MAX_EN
   logic [15:0] max_q;

   // Largest error so far; ties keep the stored value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_q <= '0;
      end else if (clear) begin
         max_q <= '0;
      end else if (s2_vld_q && (diff_q > max_q)) begin
         max_q <= diff_q;
      end
   end

   assign max_err = max_q;
`else
   assign max_err = 16'h0000;
`endif

   assign in_ready    = (state_q == ST_RUN);
   assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done        = done_q;
   assign sum_abs_err = sum_q;
   assign err_cnt     = err_cnt_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_mult_err_accum.sv
// Testbench for mult_err_accum with N_LOG2=2 (four samples per run).
// Accepted samples are queued; expected results are computed from the
// queue with plain integer arithmetic when a run finishes.
module tb_mult_err_accum;
  localparam int N_LOG2 = 2;
  localparam int NS     = 1 << N_LOG2;

  logic               clk;
  logic               rst;
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         a;
  logic [7:0]         b;
  logic [15:0]        r_apx;
  logic               busy;
  logic               done;
  logic [15+N_LOG2:0] sum_abs_err;
  logic [N_LOG2:0]    err_cnt;
  logic [15:0]        max_err;
  logic [1:0]         state_o;

  int checks = 0;
  int errors = 0;

  // scoreboard: accepted samples of the current run, {a, b, r_apx}
  logic [31:0] exp_q[$];

  mult_err_accum #(.N_LOG2(N_LOG2)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .r_apx(r_apx), .busy(busy),
    .done(done), .sum_abs_err(sum_abs_err), .err_cnt(err_cnt),
    .max_err(max_err), .state_o(state_o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // driver tasks (all entered and left at a falling edge)
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; r_apx = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] rv,
                      input int gap);
    in_valid = 1'b1; a = av; b = bv; r_apx = rv;
    check_eq("in_ready_run", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    exp_q.push_back({av, bv, rv});
    @(negedge clk);
    // garbage on the data lines during bubbles must be ignored
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); r_apx = 16'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  // called at the falling edge right after the final acceptance
  task automatic wait_done(input string tag);
    int n;
    check_eq({tag, "_drain_ready"}, {31'd0, in_ready}, 32'd0);
    check_eq({tag, "_drain_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check_eq({tag, "_done_latency"}, n, 32'd3);
    @(negedge clk);
  endtask

  task automatic check_results(input string tag);
    int sum, cnt, mx, p, r, e;
    sum = 0; cnt = 0; mx = 0;
    foreach (exp_q[i]) begin
      p = int'(exp_q[i][31:24]) * int'(exp_q[i][23:16]);
      r = int'(exp_q[i][15:0]);
      e = (p > r) ? p - r : r - p;
      sum += e;
      if (e != 0) cnt++;
      if (e > mx) mx = e;
    end
`ifndef MULT_ERR_MAX_EN
    mx = 0;
`endif
    check_eq({tag, "_sum"}, 32'(sum_abs_err), sum);
    check_eq({tag, "_cnt"}, 32'(err_cnt), cnt);
    check_eq({tag, "_max"}, 32'(max_err), mx);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq({tag, "_hold_sum"}, 32'(sum_abs_err), sum);
    check_eq({tag, "_hold_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic send_exact(input int gap);
    logic [7:0] av, bv;
    av = 8'($urandom); bv = 8'($urandom);
    send(av, bv, 16'(av * bv), gap);
  endtask

  initial begin
    do_reset();
    check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_sum", 32'(sum_abs_err), 32'd0);
    check_eq("rst_cnt", 32'(err_cnt), 32'd0);
    check_eq("rst_max", 32'(max_err), 32'd0);
    check_eq("rst_state", 32'(state_o), 32'd0);
    repeat (4) @(negedge clk);
    check_eq("idle_wait_busy", {31'd0, busy}, 32'd0);

    // all exact samples
    do_start();
    check_eq("start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < NS; i++) send_exact(0);
    wait_done("exact");
    check_results("exact");

    // one off-by-one sample, start from DONE must clear the results
    do_start();
    check_eq("restart_done", {31'd0, done}, 32'd0);
    check_eq("restart_sum", 32'(sum_abs_err), 32'd0);
    send(8'd255, 8'd255, 16'd65024, 0);
    for (int i = 1; i < NS; i++) send_exact(0);
    wait_done("one_err");
    check_results("one_err");

    // errors 10, 0, 300, 300 with bubbles between samples
    do_start();
    send(8'd10, 8'd10, 16'd90, 1);
    send(8'd3, 8'd7, 16'd21, 1);
    send(8'd20, 8'd20, 16'd100, 1);
    send(8'd1, 8'd1, 16'd301, 0);
    wait_done("bubbles");
    check_results("bubbles");

    // start mid-run is ignored
    do_start();
    send(8'd10, 8'd10, 16'd90, 0);
    send(8'd3, 8'd7, 16'd30, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("midstart_busy", {31'd0, busy}, 32'd1);
    send(8'd20, 8'd20, 16'd100, 0);
    send(8'd1, 8'd1, 16'd301, 0);
    wait_done("midstart");
    check_results("midstart");

    // asynchronous reset mid-run, then a clean run
    do_start();
    send(8'd200, 8'd200, 16'd5, 0);
    send(8'd100, 8'd3, 16'd0, 0);
    send(8'd9, 8'd9, 16'd1000, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_ready", {31'd0, in_ready}, 32'd0);
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_done", {31'd0, done}, 32'd0);
    check_eq("arst_sum", 32'(sum_abs_err), 32'd0);
    check_eq("arst_cnt", 32'(err_cnt), 32'd0);
    check_eq("arst_max", 32'(max_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("arst_idle_busy", {31'd0, busy}, 32'd0);
    do_start();
    for (int i = 0; i < NS; i++) send_exact(0);
    wait_done("post_rst");
    check_results("post_rst");

    // randomized runs
    for (int run = 0; run < 8; run++) begin
      do_start();
      for (int i = 0; i < NS; i++) begin
        logic [7:0]  av, bv;
        logic [15:0] rv;
        av = 8'($urandom); bv = 8'($urandom);
        case ($urandom_range(0, 2))
          0:       rv = 16'(av * bv);
          1:       rv = 16'(av * bv) ^ 16'($urandom_range(1, 255));
          default: rv = 16'($urandom);
        endcase
        send(av, bv, rv, (i == NS - 1) ? 0 : $urandom_range(0, 2));
      end
      wait_done("rand");
      check_results("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
